bpsk_modulator: RTL and testbench
=================================

Name: bpsk_modulator

Overview:
- Transmit-side counterpart of the correlation demodulator.
- Accepts a serial bit stream through a valid/ready handshake and buffers it in a small FIFO.
- Emits one BPSK symbol per bit: 32 samples of an 8-bit offset sine per symbol, at one sample per clk_fast cycle. Bit 1 gives phase 0; bit 0 gives phase 180.
- wav_out drives the DAC path; the waveform is sample-compatible with the demodulator's 32-tap reference sine.

Parameters:
- FIFO_DEPTH, 4, bit buffer depth; must be a power of two, at least 2.
- IDLE_LEVEL, 8'h40, DAC midscale code driven when no symbol is active.

Ports:
- clk_fast  in  1  sample clock
- rst  in  1  asynchronous, active-low reset
- bit_in  in  1  data bit to transmit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  FIFO can accept a bit
- wav_out  out  8  registered DAC sample
- wav_valid  out  1  wav_out carries a symbol sample
- sym_start  out  1  pulses on sample index 0 of each symbol
- busy  out  1  a symbol is in progress or the FIFO is non-empty

Behaviour:
- Reset is asynchronous and active-low on rst; clock is clk_fast.
- Reset values: wav_out=IDLE_LEVEL, wav_valid=0, sym_start=0, busy=0, bit_ready=1. FIFO is emptied, phase counter=0, state=IDLE.
- Handshake: a bit is accepted on a rising edge with bit_valid && bit_ready.
  - bit_ready = !fifo_full, combinational from FIFO state.
  - Simultaneous push and pop while full is not allowed; ready already reflects full.
- Sine ROM: 32 entries, SIN[k] = 0x40 + round(64*sin(2*pi*k/32)), k=0..31.
  - Key values: SIN[0]=0x40, SIN[1]=0x4C, SIN[8]=0x80, SIN[16]=0x40, SIN[24]=0x00.
  - Inverted sample = 8'h80 - SIN[k]. No overflow is possible; the range stays within 0x00..0x80.
- FSM IDLE:
  - wav_out=IDLE_LEVEL, wav_valid=0.
  - If the FIFO is non-empty: pop, latch the bit into cur_bit, phase=0, go to SEND.
- FSM SEND, each cycle:
  - wav_out <= cur_bit ? SIN[phase] : 8'h80-SIN[phase]; wav_valid<=1; sym_start<=(phase==0).
  - phase increments mod 32.
  - At phase==31: if the FIFO is non-empty, pop, load the next bit, phase wraps to 0, stay in SEND. This gives gapless back-to-back symbols with no idle sample. Otherwise go to IDLE; the next cycle outputs IDLE_LEVEL.
- Latency: a bit accepted at edge t into an empty FIFO in IDLE is popped at edge t+1. Its sample 0 appears on wav_out after edge t+2.
- Symbol length is exactly 32 cycles. Bit order is FIFO order.
- busy = (state==SEND) || !fifo_empty.
- Boundaries:
  - FIFO full: bit_ready=0, input is held off, no bits are dropped.
  - A push into an empty FIFO at the same edge as the phase==31 check is not visible until the next edge. The modulator goes to IDLE and restarts one idle sample later.
  - A push and pop at the same edge while not full keeps the count unchanged.
  - Reset mid-symbol: outputs return to reset values immediately, the symbol is truncated, and FIFO contents are discarded.

Optional Feature:
- Macro DIFF_ENC_EN.
- Defined: differential encoding (DBPSK).
  - Register ref_phase resets to 0.
  - On each pop: ref_phase <= ref_phase ^ ~bit. Bit 1 keeps the phase; bit 0 flips it.
  - The waveform uses ref_phase in place of cur_bit; ref_phase=0 means non-inverted.
  - ref_phase persists across IDLE periods and is cleared only by reset.
- Undefined: absolute BPSK as above. ref_phase logic is absent.

Decomposition:
- Shared package mod_pkg:
  - SAMPLES_PER_SYM=32 and its log2 PHASE_W=5.
  - SINE_LUT constant array, shared with the demodulator's reference table.
  - MID_LEVEL=8'h40.
  - State enum {IDLE, SEND}.
- Sub-module mod_bit_fifo: 1-bit-wide synchronous FIFO with push, pop, full, empty and async active-low reset.

Test Plan:
- Reset, single bit 1: wav_out=40,4C,58,64,...,80 at idx 8, 40 at idx 16, 00 at idx 24, ends at 34. Sample 0 appears 2 cycles after accept. Then 40 with wav_valid=0. sym_start fires once.
- Single bit 0: samples 40,34,28,... with 00 at idx 8 and 80 at idx 24. Every sample equals 0x80 minus the bit-1 sample.
- Bits 1,0,1 pushed back-to-back: 96 contiguous valid samples, sym_start at cycles 0, 32, 64, no idle gap. busy drops one cycle after the last sample.
- Hold bit_valid=1 with a pattern of 6 bits, FIFO_DEPTH=4: bit_ready deasserts while full. All 6 bits are transmitted in order and none are lost.
- Assert rst at sample 10 of a symbol with 2 bits queued: wav_out=40, wav_valid=0 immediately. No symbol follows after release.
- DIFF_ENC_EN defined, bits 1,0,0,1: phases are non-inverted, inverted, non-inverted, non-inverted.

Source files
------------

// File: rtl/mod_pkg.sv
// -----------------------------------------------------------------------------
// mod_pkg
// Definitions shared by the BPSK modulator and the correlation demodulator:
// symbol geometry, the 32-entry offset sine table, the DAC midscale code and
// the modulator state encoding.
// -----------------------------------------------------------------------------
package mod_pkg;

  localparam int SAMPLES_PER_SYM = 32;
  localparam int PHASE_W         = 5;

  localparam logic [7:0] MID_LEVEL = 8'h40;

  // SIN[k] = 0x40 + round(64*sin(2*pi*k/32)). Index 0 is the leftmost entry.
  localparam logic [0:SAMPLES_PER_SYM-1][7:0] SINE_LUT = {
    8'h40, 8'h4C, 8'h58, 8'h64, 8'h6D, 8'h75, 8'h7B, 8'h7F,
    8'h80, 8'h7F, 8'h7B, 8'h75, 8'h6D, 8'h64, 8'h58, 8'h4C,
    8'h40, 8'h34, 8'h28, 8'h1C, 8'h13, 8'h0B, 8'h05, 8'h01,
    8'h00, 8'h01, 8'h05, 8'h0B, 8'h13, 8'h1C, 8'h28, 8'h34
  };

  typedef enum logic {
    IDLE,
    SEND
  } mod_state_t;

endpackage

// File: rtl/mod_bit_fifo.sv
// -----------------------------------------------------------------------------
// mod_bit_fifo
// 1-bit-wide synchronous FIFO. Pushes while full and pops while empty are
// ignored. dout shows the oldest entry whenever empty is low.
//
// Ports:
//   clk_fast  in   clock
//   rst       in   asynchronous active-low reset (empties the FIFO)
//   push      in   write din this cycle
//   pop       in   discard the head entry this cycle
//   din       in   data bit to write
//   dout      out  head entry (valid when !empty)
//   full      out  no free slot
//   empty     out  no stored entry
// -----------------------------------------------------------------------------
module mod_bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_fast,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [DEPTH-1:0] mem;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk_fast) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bpsk_modulator.sv
// -----------------------------------------------------------------------------
// bpsk_modulator
// Buffers a serial bit stream and emits one 32-sample BPSK symbol per bit on
// the DAC path, one sample per clk_fast cycle. Bit 1 sends the offset sine as
// stored, bit 0 sends it mirrored about midscale (8'h80 - SIN[k]). Queued bits
// follow each other without any idle sample in between.
//
// Build option: define DIFF_ENC_EN for differential encoding (DBPSK). A
// reference phase, cleared only by reset, toggles on every popped 0 bit and
// selects the mirrored waveform when set.
//
// Ports:
//   clk_fast   in   sample clock
//   rst        in   asynchronous active-low reset
//   bit_in     in   data bit to transmit
//   bit_valid  in   bit_in is valid
//   bit_ready  out  FIFO can accept a bit
//   wav_out    out  registered DAC sample (IDLE_LEVEL when no symbol)
//   wav_valid  out  wav_out carries a symbol sample
//   sym_start  out  high with sample index 0 of each symbol
//   busy       out  a symbol is in progress or bits are queued
// -----------------------------------------------------------------------------
module bpsk_modulator
  import mod_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_LEVEL = MID_LEVEL
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] wav_out,
  output logic       wav_valid,
  output logic       sym_start,
  output logic       busy
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SAMPLES_PER_SYM - 1);

  mod_state_t         state;
  logic [PHASE_W-1:0] phase;
  logic               cur_bit;     // 1 = send the sine as stored
  logic               fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               load_bit;    // polarity taken on by the next symbol

  // Stored sine sample or its mirror about midscale; 8'h80 - SIN[k] stays
  // inside 0x00..0x80 so no saturation is needed.
  function automatic logic [7:0] sample_for(input logic noninv,
                                            input logic [PHASE_W-1:0] idx);
    logic [7:0] s;
    s = SINE_LUT[idx];
    return noninv ? s : (8'h80 - s);
  endfunction

  assign bit_ready = !fifo_full;
  assign push      = bit_valid && bit_ready;
  // Fetch a bit when idle, or at the last sample so the next symbol is gapless.
  assign pop       = !fifo_empty && ((state == IDLE) || (phase == LAST_PHASE));
  assign busy      = (state == SEND) || !fifo_empty;

  mod_bit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_fast(clk_fast),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (bit_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef DIFF_ENC_EN
  logic ref_phase;
  // New ref_phase is ref_phase ^ ~bit; the symbol is non-inverted when it is 0.
  assign load_bit = ref_phase ^ fifo_dout;
`else
  assign load_bit = fifo_dout;
`endif

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase     <= '0;
      cur_bit   <= 1'b0;
      wav_out   <= IDLE_LEVEL;
      wav_valid <= 1'b0;
      sym_start <= 1'b0;
`ifdef DIFF_ENC_EN
      ref_phase <= 1'b0;
`endif
    end else begin
`ifdef DIFF_ENC_EN
      if (pop) ref_phase <= ref_phase ^ ~fifo_dout;
`endif
      case (state)
        IDLE: begin
          wav_out   <= IDLE_LEVEL;
          wav_valid <= 1'b0;
          sym_start <= 1'b0;
          if (pop) begin
            cur_bit <= load_bit;
            phase   <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          wav_out   <= sample_for(cur_bit, phase);
          wav_valid <= 1'b1;
          sym_start <= (phase == '0);
          phase     <= phase + 1'b1;
          if (phase == LAST_PHASE) begin
            if (pop) cur_bit <= load_bit;
            else     state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// -----------------------------------------------------------------------------
// tb_bpsk_modulator
// Self-checking bench for bpsk_modulator: fixed key-sample table, hand-written
// latency / back-to-back / back-pressure / reset sequences, and a randomized
// bit stream compared against a sine model computed with $sin.
// -----------------------------------------------------------------------------
module tb_bpsk_modulator;

  logic       clk_fast = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] wav_out;
  logic       wav_valid;
  logic       sym_start;
  logic       busy;

  bpsk_modulator dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .wav_out  (wav_out),
    .wav_valid(wav_valid),
    .sym_start(sym_start),
    .busy     (busy)
  );

  always #5 clk_fast = ~clk_fast;

  int total = 0;
  int bad   = 0;

  // Captured valid samples, their sym_start flags and cycle stamps.
  int   got[$];
  bit   ss[$];
  int   cyc[$];
  int   exp_q[$];
  int   cycle = 0;
  bit   model_ref = 1'b0;
  bit   saw_stall;

  always @(negedge clk_fast) begin
    cycle++;
    if (wav_valid) begin
      got.push_back(int'(wav_out));
      ss.push_back(sym_start);
      cyc.push_back(cycle);
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int sin_ref(input int k);
    real r;
    r = 64.0 * $sin(2.0 * 3.141592653589793 * k / 32.0);
    if (r >= 0.0) return 64 + $rtoi(r + 0.5);
    else          return 64 - $rtoi(-r + 0.5);
  endfunction

  // Append the 32 samples one transmitted bit should produce.
  task automatic expect_bit(input bit b);
    bit noninv;
`ifdef DIFF_ENC_EN
    model_ref = model_ref ^ ~b;
    noninv    = ~model_ref;
`else
    noninv    = b;
`endif
    for (int k = 0; k < 32; k++)
      exp_q.push_back(noninv ? sin_ref(k) : 128 - sin_ref(k));
  endtask

  task automatic clear_capture();
    got.delete();
    ss.delete();
    cyc.delete();
    exp_q.delete();
  endtask

  // Present a bit and keep it until accepted; bit_valid stays high afterwards.
  task automatic push(input bit b);
    int n = 0;
    @(negedge clk_fast);
    bit_in    = b;
    bit_valid = 1'b1;
    while (!bit_ready && n < 200) begin
      saw_stall = 1'b1;
      @(negedge clk_fast);
      n++;
    end
    if (n >= 200) check("push_timeout", 0, 1);
    @(posedge clk_fast);
  endtask

  task automatic release_valid();
    @(negedge clk_fast);
    bit_valid = 1'b0;
  endtask

  task automatic wait_samples(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk_fast);
      #1;
      c++;
    end
    if (got.size() < n) check("sample_wait_timeout", got.size(), n);
  endtask

  task automatic compare_stream(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check({name, "_sample"}, got[i], exp_q[i]);
      else                check({name, "_missing"}, -1, exp_q[i]);
    end
  endtask

  typedef struct {
    bit b;
    int idx;
    int wav;
  } vec_t;

  vec_t tbl[12];
  int   sym1[32];
  int   sym0[32];
  int   ss_cnt;
  int   keep;
  bit   pat6[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  bit   rb;

  initial begin
    tbl[0]  = '{1'b1, 0,  'h40};
    tbl[1]  = '{1'b1, 1,  'h4C};
    tbl[2]  = '{1'b1, 2,  'h58};
    tbl[3]  = '{1'b1, 3,  'h64};
    tbl[4]  = '{1'b1, 8,  'h80};
    tbl[5]  = '{1'b1, 16, 'h40};
    tbl[6]  = '{1'b1, 24, 'h00};
    tbl[7]  = '{1'b1, 31, 'h34};
    tbl[8]  = '{1'b0, 0,  'h40};
    tbl[9]  = '{1'b0, 1,  'h34};
    tbl[10] = '{1'b0, 8,  'h00};
    tbl[11] = '{1'b0, 24, 'h80};

    rst       = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    saw_stall = 1'b0;

    // ---- reset state
    repeat (3) @(negedge clk_fast);
    check("rst_wav_out",   int'(wav_out), 'h40);
    check("rst_wav_valid", int'(wav_valid), 0);
    check("rst_sym_start", int'(sym_start), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_bit_ready", int'(bit_ready), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk_fast);
    check("idle_wav_out", int'(wav_out), 'h40);

    // ---- single bit 1 with latency
    clear_capture();
    expect_bit(1'b1);
    push(1'b1);
    release_valid();
    check("lat_t0_valid", int'(wav_valid), 0);
    @(negedge clk_fast);
    check("lat_t1_valid", int'(wav_valid), 0);
    check("lat_t1_busy",  int'(busy), 1);
    @(negedge clk_fast);
    check("lat_t2_valid", int'(wav_valid), 1);
    check("lat_t2_wav",   int'(wav_out), 'h40);
    check("lat_t2_start", int'(sym_start), 1);
    wait_samples(32, 200);
    @(negedge clk_fast);
    check("bit1_end_valid", int'(wav_valid), 0);
    check("bit1_end_wav",   int'(wav_out), 'h40);
    check("bit1_end_busy",  int'(busy), 0);
    compare_stream("bit1");
    ss_cnt = 0;
    foreach (ss[i]) ss_cnt += int'(ss[i]);
    check("bit1_sym_start_count", ss_cnt, 1);
    for (int k = 0; k < 32; k++) sym1[k] = (k < got.size()) ? got[k] : -1;

    // ---- single bit 0
    clear_capture();
    expect_bit(1'b0);
    push(1'b0);
    release_valid();
    wait_samples(32, 200);
    compare_stream("bit0");
    for (int k = 0; k < 32; k++) sym0[k] = (k < got.size()) ? got[k] : -1;
    for (int k = 0; k < 32; k++) check("bit0_mirror", sym0[k], 128 - sym1[k]);

    // ---- key-sample table
    for (int i = 0; i < 12; i++)
      check($sformatf("tbl_b%0d_k%0d", tbl[i].b, tbl[i].idx),
            tbl[i].b ? sym1[tbl[i].idx] : sym0[tbl[i].idx], tbl[i].wav);

    // ---- 1,0,1 back-to-back
    repeat (2) @(negedge clk_fast);
    clear_capture();
    expect_bit(1'b1);
    expect_bit(1'b0);
    expect_bit(1'b1);
    push(1'b1);
    push(1'b0);
    push(1'b1);
    release_valid();
    wait_samples(96, 400);
    @(negedge clk_fast);
    check("b2b_end_valid", int'(wav_valid), 0);
    check("b2b_end_busy",  int'(busy), 0);
    compare_stream("b2b");
    for (int i = 1; i < 96 && i < cyc.size(); i++)
      check("b2b_gapless", cyc[i] - cyc[i-1], 1);
    for (int i = 0; i < 96 && i < ss.size(); i++)
      check("b2b_sym_start", int'(ss[i]), (i % 32 == 0) ? 1 : 0);

    // ---- six bits held against a full FIFO
    repeat (2) @(negedge clk_fast);
    clear_capture();
    saw_stall = 1'b0;
    foreach (pat6[i]) begin
      expect_bit(pat6[i]);
      push(pat6[i]);
    end
    release_valid();
    check("full_backpressure_seen", int'(saw_stall), 1);
    wait_samples(192, 800);
    compare_stream("full6");
    check("full6_count", got.size(), 192);

    // ---- reset mid-symbol with two bits queued
    repeat (3) @(negedge clk_fast);
    clear_capture();
    push(1'b1);
    push(1'b0);
    push(1'b1);
    release_valid();
    wait_samples(11, 200);
    rst = 1'b0;
    #1;
    check("midrst_wav_out",   int'(wav_out), 'h40);
    check("midrst_wav_valid", int'(wav_valid), 0);
    check("midrst_sym_start", int'(sym_start), 0);
    check("midrst_busy",      int'(busy), 0);
    check("midrst_bit_ready", int'(bit_ready), 1);
    repeat (3) @(negedge clk_fast);
    rst = 1'b1;
    model_ref = 1'b0;
    keep = got.size();
    repeat (60) @(negedge clk_fast);
    check("midrst_no_more_samples", got.size(), keep);
    check("midrst_idle_busy", int'(busy), 0);

    // ---- randomized stream with random idle gaps
    clear_capture();
    for (int i = 0; i < 10; i++) begin
      rb = 1'($urandom_range(0, 1));
      expect_bit(rb);
      push(rb);
      if ($urandom_range(0, 3) == 0) begin
        release_valid();
        repeat ($urandom_range(0, 40)) @(negedge clk_fast);
      end
    end
    release_valid();
    wait_samples(320, 3000);
    compare_stream("rand");
    repeat (2) @(negedge clk_fast);
    check("rand_end_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
